rv_exec_mem_unit: RTL and testbench

Combinational decode, execute and data-memory slice of the single-cycle RV32I core. It takes the decoded instruction fields and the register-file operands, and produces the ALU result, the branch decision and the write-back control. It also holds the word-addressed data memory. It sits between the register file/immediate generator and the write-back mux/PC-update logic.

---
 rtl/rv_exec_mem_unit_pkg.sv | 54 +++++
 rtl/rv_exec_mem_unit_dmem.sv | 32 +++
 rtl/rv_exec_mem_unit.sv | 137 +++++++++++++
 tb/tb_rv_exec_mem_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_exec_mem_unit_pkg.sv
// Shared constants for the RV32I execute/memory slice:
// opcodes, ALU operation codes and default memory depth.
package rv_exec_mem_unit_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_LT   = 4'd12;
  localparam logic [3:0] ALU_GE   = 4'd13;
  localparam logic [3:0] ALU_LTU  = 4'd14;
  localparam logic [3:0] ALU_GEU  = 4'd15;

  localparam int DMEM_WORDS_DEF = 256;

  // R-type and I-ALU share one funct3 map; only R-type
  // lets funct7[5] turn ADD into SUB.
  function automatic logic [3:0] alu_op_map(
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       allow_sub
  );
    logic [3:0] op;
    op = ALU_ADD;
    unique case (f3)
      3'd0: op = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1: op = ALU_SLL;
      3'd2: op = ALU_SLT;
      3'd3: op = ALU_SLTU;
      3'd4: op = ALU_XOR;
      3'd5: op = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6: op = ALU_OR;
      3'd7: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_exec_mem_unit_dmem.sv
// Word-addressed data memory: combinational gated read,
// posedge write, asynchronous clear on rst.
module exec_dmem
  import rv_exec_mem_unit_pkg::*;
#(
  parameter int WORDS = DMEM_WORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(WORDS)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  // Clear wins over write, so a store under rst is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = re ? mem[idx] : '0;

endmodule

// File: rtl/rv_exec_mem_unit.sv
// Single-cycle RV32I decode, ALU, branch decision and
// data memory slice.
module rv_exec_mem_unit
  import rv_exec_mem_unit_pkg::*;
#(
  parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_result,
  output logic [31:0] mem_read_data,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        branch,
  output logic        is_jump,
  output logic        branch_taken
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic        no_take;
  logic        branch_condition;
  logic [31:0] op2;
  logic [31:0] diff;
  logic        unused_f7;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  // Main decoder: control flags and ALU operation.
  always_comb begin
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src     = 1'b0;
    branch      = 1'b0;
    is_jump     = 1'b0;
    no_take     = 1'b0;
    alu_control = ALU_ADD;
    unique case (opcode)
      OP_R: begin
        reg_write   = 1'b1;
        alu_control = alu_op_map(funct3, funct7[5], 1'b1);
      end
      OP_I: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = alu_op_map(funct3, funct7[5], 1'b0);
      end
      OP_LOAD: begin
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        alu_src    = 1'b1;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        branch = 1'b1;
        unique case (funct3)
          3'd0: alu_control = ALU_EQ;
          3'd1: alu_control = ALU_NE;
          3'd4: alu_control = ALU_LT;
          3'd5: alu_control = ALU_GE;
          3'd6: alu_control = ALU_LTU;
          3'd7: alu_control = ALU_GEU;
          default: begin
            alu_control = ALU_EQ;
            no_take     = 1'b1;
          end
        endcase
      end
      OP_JAL: begin
        is_jump   = 1'b1;
        reg_write = 1'b1;
      end
      default: begin
        alu_control = ALU_ADD;
      end
    endcase
  end

  assign op2  = alu_src ? imm : rs2_data;
  assign diff = rs1_data - op2;

  // ALU datapath and compare outcome.
  always_comb begin
    alu_result       = diff;
    branch_condition = 1'b0;
    unique case (alu_control)
      ALU_ADD:  alu_result = rs1_data + op2;
      ALU_SUB:  alu_result = diff;
      ALU_AND:  alu_result = rs1_data & op2;
      ALU_OR:   alu_result = rs1_data | op2;
      ALU_XOR:  alu_result = rs1_data ^ op2;
      ALU_SLL:  alu_result = rs1_data << op2[4:0];
      ALU_SRL:  alu_result = rs1_data >> op2[4:0];
      ALU_SRA:  alu_result = $signed(rs1_data) >>> op2[4:0];
      ALU_SLT:  alu_result = {31'b0, $signed(rs1_data) < $signed(op2)};
      ALU_SLTU: alu_result = {31'b0, rs1_data < op2};
      ALU_EQ:   branch_condition = rs1_data == op2;
      ALU_NE:   branch_condition = rs1_data != op2;
      ALU_LT:   branch_condition = $signed(rs1_data) < $signed(op2);
      ALU_GE:   branch_condition = $signed(rs1_data) >= $signed(op2);
      ALU_LTU:  branch_condition = rs1_data < op2;
      ALU_GEU:  branch_condition = rs1_data >= op2;
      default:  alu_result = diff;
    endcase
  end

  assign branch_taken = is_jump | (branch & branch_condition & ~no_take);

  exec_dmem #(
    .WORDS(DMEM_WORDS)
  ) u_dmem (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_write),
    .re   (mem_read),
    .idx  (alu_result[AW+1:2]),
    .wdata(rs2_data),
    .rdata(mem_read_data)
  );

endmodule

// File: tb/tb_rv_exec_mem_unit.sv
// Self-checking bench for rv_exec_mem_unit: directed
// scenarios plus random instructions against a reference.
module tb_rv_exec_mem_unit;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] LU = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [3:0]  alu_control;
  logic [31:0] alu_result, mem_read_data;
  logic reg_write, mem_read, mem_write, mem_to_reg;
  logic alu_src, branch, is_jump, branch_taken;
  logic [7:0]  flags;

  int checks = 0;
  int failures = 0;
  logic [31:0] mref [256];

  always #5 clk = ~clk;

  assign flags = {reg_write, mem_read, mem_write, mem_to_reg,
                  alu_src, branch, is_jump, branch_taken};

  rv_exec_mem_unit #(.DMEM_WORDS(256)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .alu_control(alu_control), .alu_result(alu_result),
    .mem_read_data(mem_read_data), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch),
    .is_jump(is_jump), .branch_taken(branch_taken)
  );

  // Instruction-level reference: what each RV32I op means.
  function automatic void model(
    input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] a, b, im,
    output logic [7:0] fl, output logic [3:0] code,
    output logic [31:0] res
  );
    logic rw, mr, mw, mtr, as, br, j, bt;
    logic [31:0] o;
    {rw, mr, mw, mtr, as, br, j, bt} = '0;
    code = 4'd0;
    case (op)
      R:  rw = 1;
      I:  begin rw = 1; as = 1; end
      LD: begin rw = 1; mr = 1; mtr = 1; as = 1; end
      ST: begin mw = 1; as = 1; end
      BR: br = 1;
      JL: begin j = 1; rw = 1; bt = 1; end
      default: ;
    endcase
    o = as ? im : b;
    res = a + o;
    if (op == R || op == I) begin
      case (f3)
        0: if (op == R && f7[5]) begin code = 1; res = a - o; end
        1: begin code = 5; res = a << o[4:0]; end
        2: begin code = 8; res = ($signed(a) < $signed(o)) ? 1 : 0; end
        3: begin code = 9; res = (a < o) ? 1 : 0; end
        4: begin code = 4; res = a ^ o; end
        5: if (f7[5]) begin
             code = 7; res = $signed(a) >>> o[4:0];
           end else begin
             code = 6; res = a >> o[4:0];
           end
        6: begin code = 3; res = a | o; end
        default: begin code = 2; res = a & o; end
      endcase
    end else if (op == BR) begin
      res = a - o;
      case (f3)
        0: begin code = 10; bt = (a == o); end
        1: begin code = 11; bt = (a != o); end
        4: begin code = 12; bt = $signed(a) < $signed(o); end
        5: begin code = 13; bt = $signed(a) >= $signed(o); end
        6: begin code = 14; bt = a < o; end
        7: begin code = 15; bt = a >= o; end
        default: begin code = 10; bt = 0; end
      endcase
    end
    fl = {rw, mr, mw, mtr, as, br, j, bt};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7,
                       input logic [31:0] a, b, im);
    @(negedge clk);
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_data = a; rs2_data = b; imm = im;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(LD, 3'd2, 7'd0, 32'h0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(LD, 3'd2, 7'd0, $urandom, 32'h0, 32'h0);
      checks++;
      if (mem_read_data !== 32'h0) begin
        $display("FAIL reset_mem got=%h exp=0", mem_read_data);
        failures++;
      end
    end
    drive(R, 3'd0, 7'd0, 32'd9, 32'd4, 32'd0);
    checks++;
    if (alu_result !== 32'd13 || flags !== 8'h80) begin
      $display("FAIL reset_alu got=%h/%h exp=0000000d/80",
               alu_result, flags);
      failures++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 256; k++) mref[k] = '0;
  endtask

  task automatic test_r_add_sub;
    drive(R, 3'd0, 7'h00, 32'd5, 32'd3, 32'd0);
    checks++;
    if (alu_result !== 32'd8 || reg_write !== 1'b1) begin
      $display("FAIL r_add got=%h rw=%b exp=8 rw=1",
               alu_result, reg_write);
      failures++;
    end
    drive(R, 3'd0, 7'h20, 32'd5, 32'd3, 32'd0);
    checks++;
    if (alu_result !== 32'd2 || alu_control !== 4'd1) begin
      $display("FAIL r_sub got=%h ctl=%0d exp=2 ctl=1",
               alu_result, alu_control);
      failures++;
    end
    drive(I, 3'd0, 7'h20, 32'd5, 32'd3, 32'd10);
    checks++;
    if (alu_result !== 32'd15) begin
      $display("FAIL i_add_f7 got=%h exp=f", alu_result);
      failures++;
    end
  endtask

  task automatic test_cmp_shift;
    drive(R, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0);
    checks++;
    if (alu_result !== 32'd1) begin
      $display("FAIL slt got=%h exp=1", alu_result);
      failures++;
    end
    drive(R, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0);
    checks++;
    if (alu_result !== 32'd0) begin
      $display("FAIL sltu got=%h exp=0", alu_result);
      failures++;
    end
    drive(I, 3'd5, 7'h20, 32'h80000000, 32'd0, 32'd4);
    checks++;
    if (alu_result !== 32'hF8000000 || alu_src !== 1'b1) begin
      $display("FAIL srai got=%h exp=f8000000", alu_result);
      failures++;
    end
  endtask

  task automatic test_store_load;
    drive(ST, 3'd2, 7'd0, 32'h10, 32'hDEADBEEF, 32'd4);
    checks++;
    if (mem_write !== 1'b1 || alu_result !== 32'h14) begin
      $display("FAIL sw_ctl got=%b/%h exp=1/14",
               mem_write, alu_result);
      failures++;
    end
    @(posedge clk);
    mref[5] = 32'hDEADBEEF;
    drive(LD, 3'd2, 7'd0, 32'h10, 32'h0, 32'd4);
    checks++;
    if (mem_read_data !== 32'hDEADBEEF || mem_to_reg !== 1'b1) begin
      $display("FAIL lw got=%h m2r=%b exp=deadbeef m2r=1",
               mem_read_data, mem_to_reg);
      failures++;
    end
    drive(LD, 3'd2, 7'd0, 32'h411, 32'h0, 32'd4);
    checks++;
    if (mem_read_data !== 32'hDEADBEEF) begin
      $display("FAIL lw_wrap got=%h exp=deadbeef", mem_read_data);
      failures++;
    end
  endtask

  task automatic test_branch;
    drive(BR, 3'd0, 7'd0, 32'd7, 32'd7, 32'd0);
    checks++;
    if (branch_taken !== 1'b1 || branch !== 1'b1) begin
      $display("FAIL beq got=%b exp=1", branch_taken);
      failures++;
    end
    drive(BR, 3'd1, 7'd0, 32'd7, 32'd7, 32'd0);
    checks++;
    if (branch_taken !== 1'b0) begin
      $display("FAIL bne got=%b exp=0", branch_taken);
      failures++;
    end
    drive(BR, 3'd6, 7'd0, 32'd1, 32'hFFFFFFFF, 32'd0);
    checks++;
    if (branch_taken !== 1'b1 || alu_result !== 32'd2) begin
      $display("FAIL bltu got=%b/%h exp=1/2",
               branch_taken, alu_result);
      failures++;
    end
    drive(BR, 3'd2, 7'd0, 32'd7, 32'd7, 32'd0);
    checks++;
    if (branch_taken !== 1'b0 || alu_control !== 4'd10) begin
      $display("FAIL b_f3_2 got=%b ctl=%0d exp=0 ctl=10",
               branch_taken, alu_control);
      failures++;
    end
  endtask

  task automatic test_jal_other;
    drive(JL, 3'd0, 7'd0, 32'd100, 32'd4, 32'd0);
    checks++;
    if (flags !== 8'h83) begin
      $display("FAIL jal got=%h exp=83", flags);
      failures++;
    end
    drive(LU, 3'd3, 7'h20, 32'd1, 32'd2, 32'd3);
    checks++;
    if (flags !== 8'h00 || alu_control !== 4'd0) begin
      $display("FAIL lui got=%h ctl=%0d exp=00 ctl=0",
               flags, alu_control);
      failures++;
    end
  endtask

  task automatic test_reset_mid;
    drive(ST, 3'd2, 7'd0, 32'd12, 32'h12345678, 32'd0);
    @(posedge clk);
    drive(LD, 3'd2, 7'd0, 32'd12, 32'd0, 32'd0);
    checks++;
    if (mem_read_data !== 32'h12345678) begin
      $display("FAIL pre_rst got=%h exp=12345678", mem_read_data);
      failures++;
    end
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    for (int k = 0; k < 256; k++) mref[k] = '0;
    drive(LD, 3'd2, 7'd0, 32'd12, 32'd0, 32'd0);
    checks++;
    if (mem_read_data !== 32'h0) begin
      $display("FAIL post_rst got=%h exp=0", mem_read_data);
      failures++;
    end
    drive(ST, 3'd2, 7'd0, 32'd12, 32'hCAFEF00D, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(LD, 3'd2, 7'd0, 32'd12, 32'd0, 32'd0);
    checks++;
    if (mem_read_data !== 32'h0) begin
      $display("FAIL sw_in_rst got=%h exp=0", mem_read_data);
      failures++;
    end
  endtask

  task automatic test_random;
    logic [6:0]  ops [8];
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, im, er, ed;
    logic [7:0]  ef;
    logic [3:0]  ec;
    int          wi;
    ops = '{R, I, LD, ST, BR, JL, LU, 7'h00};
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(7)];
      if (op == 7'h00) op = 7'($urandom);
      f3 = 3'($urandom);
      f7 = ($urandom_range(1)) ? 7'h20 : 7'($urandom);
      a  = $urandom;
      b  = $urandom;
      im = $urandom;
      if ($urandom_range(3) == 0) b = a;
      if (op == LD || op == ST) a = {22'd0, 10'($urandom)};
      if (op == LD || op == ST) im = {{26{im[5]}}, im[5:0]};
      model(op, f3, f7, a, b, im, ef, ec, er);
      wi = int'(er[9:2]);
      ed = ef[6] ? mref[wi] : 32'h0;
      drive(op, f3, f7, a, b, im);
      checks++;
      if (flags !== ef) begin
        $display("FAIL rnd_flags op=%h f3=%0d got=%h exp=%h",
                 op, f3, flags, ef);
        failures++;
      end
      checks++;
      if (alu_control !== ec) begin
        $display("FAIL rnd_ctl op=%h f3=%0d got=%0d exp=%0d",
                 op, f3, alu_control, ec);
        failures++;
      end
      checks++;
      if (alu_result !== er) begin
        $display("FAIL rnd_res op=%h f3=%0d got=%h exp=%h",
                 op, f3, alu_result, er);
        failures++;
      end
      checks++;
      if (mem_read_data !== ed) begin
        $display("FAIL rnd_mem op=%h got=%h exp=%h",
                 op, mem_read_data, ed);
        failures++;
      end
      @(posedge clk);
      if (ef[5]) mref[wi] = b;
    end
  endtask

  initial begin
    opcode = '0; funct3 = '0; funct7 = '0;
    rs1_data = '0; rs2_data = '0; imm = '0;
    test_reset();
    test_r_add_sub();
    test_cmp_shift();
    test_store_load();
    test_branch();
    test_jal_other();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
